// File: rtl/vga_capture_pkg.sv
// Shared VGA timing constants, capture-window geometry and FSM state type.
// The transmitter side uses the same numbers, so both ends agree on the raster.
package vga_capture_pkg;

  localparam int unsigned H_VISIBLE    = 640;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 752;
  localparam int unsigned H_TOTAL      = 800;

  localparam int unsigned V_VISIBLE    = 480;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 492;
  localparam int unsigned V_TOTAL      = 525;

  localparam int unsigned FRAME_W = 256;
  localparam int unsigned FRAME_H = 224;
  localparam int unsigned SCALE   = 2;
  localparam int unsigned WIN_X0  = 64;
  localparam int unsigned WIN_Y0  = 16;

  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {
    StSearch,
    StVerify,
    StLocked
  } sync_state_e;

  function automatic int unsigned frame_bytes(input int unsigned w, input int unsigned h);
    return (w * h) / 8;
  endfunction

endpackage

// File: rtl/vga_capture_if.sv
// VGA input stream plus capture-RAM write port and status flags.
// master drives the video stream; slave is the capture block.
interface vga_capture_if #(
  parameter int unsigned RAM_ADDR_WIDTH = 13,
  parameter int unsigned XLEN           = 8
);
  logic [3:0]                vga_red;
  logic [3:0]                vga_green;
  logic [3:0]                vga_blue;
  logic                      h_sync;
  logic                      v_sync;
  logic [RAM_ADDR_WIDTH-1:0] cap_addr;
  logic [XLEN-1:0]           cap_data;
  logic                      cap_we;
  logic                      locked;
  logic                      frame_done;
  logic                      sync_error;

  modport master (
    output vga_red, vga_green, vga_blue, h_sync, v_sync,
    input  cap_addr, cap_data, cap_we, locked, frame_done, sync_error
  );

  modport slave (
    input  vga_red, vga_green, vga_blue, h_sync, v_sync,
    output cap_addr, cap_data, cap_we, locked, frame_done, sync_error
  );
endinterface

// File: rtl/vga_capture_packer.sv
// Packs one-bit frame samples LSB-first into bytes and issues the capture-RAM write
// for each completed byte; flags the final byte of the frame.
module vga_capture_packer
  import vga_capture_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned XLEN   = 8,
  parameter int unsigned FRM_W  = FRAME_W,
  parameter int unsigned FRM_H  = FRAME_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sample,
  input  logic              i_bit,
  input  logic [7:0]        i_fx,
  input  logic [7:0]        i_fy,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_cap_addr,
  output logic [XLEN-1:0]   o_cap_data,
  output logic              o_cap_we,
  output logic              o_frame_done
);

  localparam int unsigned       ROW_BYTES = FRM_W / 8;
  localparam logic [ADDR_W-1:0] L_LAST    = ADDR_W'(frame_bytes(FRM_W, FRM_H) - 1);

  // Only the seven older samples are kept; the eighth goes straight to the data bus.
  logic [XLEN-2:0]   r_shift;
  logic [ADDR_W-1:0] r_cap_addr;
  logic [XLEN-1:0]   r_cap_data;
  logic              r_cap_we;
  logic              r_frame_done;

  logic [ADDR_W-1:0] w_addr;
  logic              w_write;

  assign w_addr  = ADDR_W'(32'(i_fy) * ROW_BYTES + 32'(i_fx[7:3]));
  assign w_write = i_sample && !i_abort && (i_fx[2:0] == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift      <= '0;
      r_cap_addr   <= '0;
      r_cap_data   <= '0;
      r_cap_we     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_cap_we     <= w_write;
      r_frame_done <= w_write && (w_addr == L_LAST);
      if (i_abort) begin
        r_shift <= '0;
      end else if (i_sample) begin
        r_shift <= {i_bit, r_shift[XLEN-2:1]};
      end
      if (w_write) begin
        r_cap_addr <= w_addr;
        r_cap_data <= {i_bit, r_shift};
      end
    end
  end

  assign o_cap_addr   = r_cap_addr;
  assign o_cap_data   = r_cap_data;
  assign o_cap_we     = r_cap_we;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/vga_capture.sv
// VGA receiver: locks onto h/v sync timing and down-samples the active window into
// a byte-packed one-bit frame written to the capture RAM.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int unsigned RAM_SIZE       = 8 * 1024,
  parameter int unsigned RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned XLEN           = 8,
  parameter int unsigned H_FALL         = H_SYNC_START,
  parameter int unsigned H_RISE         = H_SYNC_END,
  parameter int unsigned H_TOT          = H_TOTAL,
  parameter int unsigned V_FALL         = V_SYNC_START,
  parameter int unsigned V_TOT          = V_TOTAL,
  parameter int unsigned WIN_X          = WIN_X0,
  parameter int unsigned WIN_Y          = WIN_Y0,
  parameter int unsigned FRM_W          = FRAME_W,
  parameter int unsigned FRM_H          = FRAME_H
) (
  input logic           clk,
  input logic           rst,
  vga_capture_if.slave  cap_if
);

  localparam logic [CNT_W-1:0] L_H_FALL = CNT_W'(H_FALL);
  localparam logic [CNT_W-1:0] L_H_RISE = CNT_W'(H_RISE);
  localparam logic [CNT_W-1:0] L_X_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] L_V_FALL = CNT_W'(V_FALL);
  localparam logic [CNT_W-1:0] L_Y_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] L_X0     = CNT_W'(WIN_X);
  localparam logic [CNT_W-1:0] L_X1     = CNT_W'(WIN_X + SCALE * FRM_W);
  localparam logic [CNT_W-1:0] L_Y0     = CNT_W'(WIN_Y);
  localparam logic [CNT_W-1:0] L_Y1     = CNT_W'(WIN_Y + SCALE * FRM_H);

  // r_x/r_y always hold the raster position of the pixel currently on the inputs.
  logic [CNT_W-1:0] r_x, r_y, w_x_next, w_y_next;
  logic             r_hs_prev, r_vs_prev;
  sync_state_e      r_state, w_state_next;
  logic             r_armed, w_armed_next;
  logic             r_locked, r_sync_error;

  logic       w_hs_fall, w_hs_rise, w_vs_fall, w_mismatch;
  logic       w_in_win, w_sample, w_lit;
  logic [7:0] w_fx, w_fy;

  assign w_hs_fall = r_hs_prev & ~cap_if.h_sync;
  assign w_hs_rise = ~r_hs_prev & cap_if.h_sync;
  assign w_vs_fall = r_vs_prev & ~cap_if.v_sync;

  assign w_mismatch = (r_state != StSearch) &&
                      ((w_hs_fall && (r_x != L_H_FALL)) ||
                       (w_hs_rise && (r_x != L_H_RISE)) ||
                       (w_vs_fall && ((r_x != '0) || (r_y != L_V_FALL))));

  assign w_lit    = |{cap_if.vga_red, cap_if.vga_green, cap_if.vga_blue};
  assign w_in_win = (r_x >= L_X0) && (r_x < L_X1) && (r_y >= L_Y0) && (r_y < L_Y1);
  assign w_sample = r_armed && w_in_win && !r_x[0] && !r_y[0] && !w_mismatch;
  assign w_fx     = 8'((r_x - L_X0) >> 1);
  assign w_fy     = 8'((r_y - L_Y0) >> 1);

  always_comb begin
    w_x_next = r_x + 1'b1;
    w_y_next = r_y;
    if ((r_state == StSearch) && w_vs_fall) begin
      // The falling v_sync pixel is (0, V_FALL), so the next one is x=1.
      w_x_next = CNT_W'(1);
      w_y_next = L_V_FALL;
    end else if (r_x == L_X_LAST) begin
      w_x_next = '0;
      w_y_next = (r_y == L_Y_LAST) ? '0 : r_y + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StSearch: if (w_vs_fall) w_state_next = StVerify;
      StVerify: begin
        if (w_mismatch)     w_state_next = StSearch;
        else if (w_vs_fall) w_state_next = StLocked;
      end
      StLocked: if (w_mismatch) w_state_next = StSearch;
      default:  w_state_next = StSearch;
    endcase
  end

  always_comb begin
    w_armed_next = r_armed;
    if (w_mismatch) begin
      w_armed_next = 1'b0;
    end else if ((r_state == StLocked) && (r_x == '0) && (r_y == '0)) begin
      w_armed_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_hs_prev    <= 1'b1;
      r_vs_prev    <= 1'b1;
      r_state      <= StSearch;
      r_armed      <= 1'b0;
      r_locked     <= 1'b0;
      r_sync_error <= 1'b0;
    end else begin
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_hs_prev    <= cap_if.h_sync;
      r_vs_prev    <= cap_if.v_sync;
      r_state      <= w_state_next;
      r_armed      <= w_armed_next;
      r_locked     <= (w_state_next == StLocked);
      r_sync_error <= w_mismatch;
    end
  end

  assign cap_if.locked     = r_locked;
  assign cap_if.sync_error = r_sync_error;

  vga_capture_packer #(
    .ADDR_W (RAM_ADDR_WIDTH),
    .XLEN   (XLEN),
    .FRM_W  (FRM_W),
    .FRM_H  (FRM_H)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_sample     (w_sample),
    .i_bit        (w_lit),
    .i_fx         (w_fx),
    .i_fy         (w_fy),
    .i_abort      (w_mismatch),
    .o_cap_addr   (cap_if.cap_addr),
    .o_cap_data   (cap_if.cap_data),
    .o_cap_we     (cap_if.cap_we),
    .o_frame_done (cap_if.frame_done)
  );

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced raster (50x18, 16x4 frame) so that
// many complete frames fit in a short run.
module tb_vga_capture;

  localparam int HF = 42, HR = 46, HT = 50;
  localparam int VF = 14, VR = 16, VT = 18;
  localparam int X0 = 4, Y0 = 2, FW = 16, FH = 4;
  localparam int NBYTES = FW * FH / 8;
  localparam int LAST = NBYTES - 1;

  typedef struct {
    int addr;
    int data;
    bit fd;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wr_t  sb[$];
  int   total = 0;
  int   bad = 0;
  bit   prev_we = 1'b0;

  always #5 clk = ~clk;

  vga_capture_if #(.RAM_ADDR_WIDTH(13), .XLEN(8)) vif ();

  vga_capture #(
    .RAM_SIZE       (8192),
    .RAM_ADDR_WIDTH (13),
    .XLEN           (8),
    .H_FALL         (HF),
    .H_RISE         (HR),
    .H_TOT          (HT),
    .V_FALL         (VF),
    .V_TOT          (VT),
    .WIN_X          (X0),
    .WIN_Y          (Y0),
    .FRM_W          (FW),
    .FRM_H          (FH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cap_if (vif.slave)
  );

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every write is popped against the queue of expected writes.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst) begin
      if (vif.cap_we) begin
        check("write_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("cap_addr", int'(vif.cap_addr), e.addr);
          check("cap_data", int'(vif.cap_data), e.data);
          check("frame_done", int'(vif.frame_done), int'(e.fd));
        end
      end else begin
        check("fd_without_we", int'(vif.frame_done), 0);
      end
      if (prev_we) check("we_single_cycle", int'(vif.cap_we), 0);
      prev_we = vif.cap_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  function automatic bit lit_at(input int x, input int y, input int mode);
    bit inwin;
    int fx, fy;
    inwin = (x >= X0) && (x < X0 + 2 * FW) && (y >= Y0) && (y < Y0 + 2 * FH);
    fx = (x - X0) / 2;
    fy = (y - Y0) / 2;
    case (mode)
      0: return inwin && (x == X0) && (y == Y0);
      1: return (x == X0 + 2 * (FW - 1)) && (y == Y0 + 2 * (FH - 1));
      2: return (x % 2 == 1) || (y % 2 == 1);
      3: return (x % 2 == 1) || (y % 2 == 1) || (inwin && ((fx + fy) % 3 == 0));
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_line(input int y, input int mode, input int hs_late);
    logic [11:0] c;
    for (int x = 0; x < HT; x++) begin
      @(posedge clk);
      #1;
      if (hs_late != 0) begin
        if (x == HF + 1) begin
          check("err_before_late_fall", int'(vif.sync_error), 0);
          check("locked_before_late_fall", int'(vif.locked), 1);
        end
        if (x == HF + 2) begin
          check("err_on_late_fall", int'(vif.sync_error), 1);
          check("locked_drop_on_err", int'(vif.locked), 0);
        end
        if (x == HF + 3) check("err_is_pulse", int'(vif.sync_error), 0);
      end
      c = 12'(1 << ((x + y) % 12));
      {vif.vga_red, vif.vga_green, vif.vga_blue} = lit_at(x, y, mode) ? c : 12'h000;
      vif.h_sync = (x >= HF + hs_late && x < HR) ? 1'b0 : 1'b1;
      vif.v_sync = (y >= VF && y < VR) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic drive_lines(input int y_from, input int y_to, input int mode);
    for (int y = y_from; y < y_to; y++) drive_line(y, mode, 0);
  endtask

  // Hand-computed frames: n writes from address 0, all zero except one byte.
  task automatic push_single(input int hot_addr, input int hot_data, input int n);
    wr_t w;
    for (int a = 0; a < n; a++) begin
      w.addr = a;
      w.data = (a == hot_addr) ? hot_data : 0;
      w.fd   = (a == LAST);
      sb.push_back(w);
    end
  endtask

  task automatic push_model(input int mode);
    wr_t w;
    for (int fy = 0; fy < FH; fy++) begin
      for (int b = 0; b < FW / 8; b++) begin
        w.data = 0;
        for (int i = 0; i < 8; i++) begin
          if (lit_at(X0 + 2 * (b * 8 + i), Y0 + 2 * fy, mode)) w.data = w.data | (1 << i);
        end
        w.addr = fy * (FW / 8) + b;
        w.fd   = (w.addr == LAST);
        sb.push_back(w);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cap_addr"}, int'(vif.cap_addr), 0);
    check({tag, "_cap_data"}, int'(vif.cap_data), 0);
    check({tag, "_cap_we"}, int'(vif.cap_we), 0);
    check({tag, "_locked"}, int'(vif.locked), 0);
    check({tag, "_frame_done"}, int'(vif.frame_done), 0);
    check({tag, "_sync_error"}, int'(vif.sync_error), 0);
  endtask

  initial begin
    {vif.vga_red, vif.vga_green, vif.vga_blue} = 12'h000;
    vif.h_sync = 1'b1;
    vif.v_sync = 1'b1;
    #1 rst = 1'b1;
    #2;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Acquire: first v_sync fall enters verify, second one locks.
    drive_lines(0, VT, 0);
    check("locked_after_first_vs", int'(vif.locked), 0);
    drive_lines(0, VF, 0);
    check("locked_before_second_vs", int'(vif.locked), 0);
    drive_lines(VF, VT, 0);
    check("locked_after_second_vs", int'(vif.locked), 1);

    push_single(0, 8'h01, NBYTES);
    drive_lines(0, VT, 0);
    check("sb_drained_px00", sb.size(), 0);

    push_single(LAST, 8'h80, NBYTES);
    drive_lines(0, VT, 1);
    check("sb_drained_pxlast", sb.size(), 0);

    push_single(0, 8'h00, NBYTES);
    drive_lines(0, VT, 2);
    check("sb_drained_odd", sb.size(), 0);

    push_model(3);
    drive_lines(0, VT, 3);
    check("sb_drained_pattern", sb.size(), 0);

    // Late h_sync fall on screen line 4: rows 0-1 already written, rest dropped.
    push_single(0, 8'h01, 4);
    drive_lines(0, 4, 0);
    drive_line(4, 0, 1);
    drive_lines(5, VT, 0);
    check("sb_drained_abort", sb.size(), 0);
    check("unlocked_after_err", int'(vif.locked), 0);
    drive_lines(0, VF, 0);
    check("relock_not_yet", int'(vif.locked), 0);
    drive_lines(VF, VT, 0);
    check("relocked", int'(vif.locked), 1);
    push_single(LAST, 8'h80, NBYTES);
    drive_lines(0, VT, 1);
    check("sb_drained_relock", sb.size(), 0);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    check("locked_before_async_rst", int'(vif.locked), 1);
    check("addr_before_async_rst", int'(vif.cap_addr), LAST);
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    {vif.vga_red, vif.vga_green, vif.vga_blue} = 12'h000;
    vif.h_sync = 1'b1;
    vif.v_sync = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Stream resumes mid-frame: nothing written until locked and back at (0,0).
    drive_lines(10, VT, 3);
    check("midframe_unlocked", int'(vif.locked), 0);
    drive_lines(0, VT, 3);
    check("midframe_locked", int'(vif.locked), 1);
    push_model(3);
    drive_lines(0, VT, 3);
    check("sb_drained_midframe", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
